// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: load/store type encodings, FSM states and alignment helper
// shared by the data-memory access controller.
package mem_access_ctrl_pkg;

   typedef enum logic [3:0] {
      Type_LW  = 4'd0,
      Type_LB  = 4'd1,
      Type_LBU = 4'd2,
      Type_LH  = 4'd3,
      Type_LHU = 4'd4,
      Type_LWL = 4'd5,
      Type_LWR = 4'd6,
      Type_SW  = 4'd7,
      Type_SH  = 4'd8,
      Type_SB  = 4'd9
   } mem_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   function automatic logic is_half(input logic [3:0] t);
      return t == Type_LH || t == Type_LHU || t == Type_SH;
   endfunction

   function automatic logic is_byte(input logic [3:0] t);
      return t == Type_LB || t == Type_LBU || t == Type_SB;
   endfunction

   // Unknown encodings fall into the word class, matching the byte-enable decode.
   function automatic logic misaligned(input logic [3:0] t, input logic [1:0] a);
      return is_half(t) ? a[0] :
             (is_byte(t) || t == Type_LWL || t == Type_LWR) ? 1'b0 : (a != 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_enable_gen.sv
// mem_byte_enable_gen: decodes access type and low address bits into byte-lane
// enables and lane-replicated store data.
module mem_byte_enable_gen
   import mem_access_ctrl_pkg::*;
(
   input  logic [3:0]  type_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o
);

   assign be_o = is_half(type_i)    ? (addr_i[1] ? 4'b1100 : 4'b0011) :
                 is_byte(type_i)    ? (4'b0001 << addr_i) :
                 type_i == Type_LWL ? 4'b1100 :
                 type_i == Type_LWR ? 4'b0011 : 4'b1111;

   assign wdata_o = type_i == Type_SB ? {4{wdata_i[7:0]}} :
                    type_i == Type_SH ? {2{wdata_i[15:0]}} : wdata_i;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a variable-latency memory port,
// stalling until ack or timeout. Optional misalignment trap under ALIGN_CHECK_EN.
module mem_access_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_req_valid,
   input  logic        ex_req_we,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  ex_type,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic [31:0] wb_read_data,
   output logic [1:0]  wb_select_word,
   output logic [3:0]  wb_load_type,
   output logic        timeout,
   output logic        addr_err
);
   import mem_access_ctrl_pkg::*;

   mem_state_e        st_q, st_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]        type_q, type_d, wtype_q, wtype_d;
   logic [1:0]        sel_q, sel_d;
   logic              we_q, we_d, to_q, to_d, aerr_q, aerr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [3:0]        be;
   logic [31:0]       rep_wdata;
   logic              mis;

`ifdef ALIGN_CHECK_EN
   assign mis      = misaligned(ex_type, ex_addr[1:0]);
   assign addr_err = st_q == DONE && aerr_q;
`else
   assign mis      = 1'b0;
   assign addr_err = 1'b0;
`endif

   mem_byte_enable_gen u_be (
      .type_i  (type_q),
      .addr_i  (addr_q[1:0]),
      .wdata_i (wdata_q),
      .be_o    (be),
      .wdata_o (rep_wdata)
   );

   assign cnt_inc  = cnt_q + 1'b1;
   assign dm_req   = st_q == REQ;
   assign dm_we    = dm_req && we_q;
   assign dm_addr  = dm_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign dm_be    = dm_req ? be : 4'd0;
   assign dm_wdata = dm_we ? rep_wdata : 32'd0;
   assign wb_valid = st_q == DONE && !to_q && !aerr_q;
   assign timeout  = st_q == DONE && to_q;
   assign wb_read_data   = rdata_q;
   assign wb_select_word = sel_q;
   assign wb_load_type   = wtype_q;

   always_comb begin
      st_d    = st_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      type_d  = type_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      aerr_d  = aerr_q;
      rdata_d = rdata_q;
      sel_d   = sel_q;
      wtype_d = wtype_q;
      stall   = 1'b0;
      case (st_q)
         IDLE: begin
            cnt_d  = '0;
            to_d   = 1'b0;
            aerr_d = 1'b0;
            if (ex_req_valid) begin
               stall   = 1'b1;
               addr_d  = ex_addr;
               wdata_d = ex_wdata;
               type_d  = ex_type;
               we_d    = ex_req_we;
               aerr_d  = mis;
               st_d    = mis ? DONE : REQ;
               rdata_d = mis ? 32'd0 : rdata_q;
               sel_d   = mis ? ex_addr[1:0] : sel_q;
               wtype_d = mis ? ex_type : wtype_q;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (dm_ack) begin
               st_d    = DONE;
               rdata_d = we_q ? 32'd0 : dm_rdata;
               sel_d   = addr_q[1:0];
               wtype_d = type_q;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                  st_d    = DONE;
                  to_d    = 1'b1;
                  rdata_d = 32'd0;
                  sel_d   = addr_q[1:0];
                  wtype_d = type_q;
               end
            end
         end
         DONE: begin
            cnt_d = '0;
            st_d  = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         type_q  <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         aerr_q  <= 1'b0;
         rdata_q <= '0;
         sel_q   <= '0;
         wtype_q <= '0;
      end else begin
         st_q    <= st_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         type_q  <= type_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         aerr_q  <= aerr_d;
         rdata_q <= rdata_d;
         sel_q   <= sel_d;
         wtype_q <= wtype_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl
// (covers both default and ALIGN_CHECK_EN builds).
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_req_valid, ex_req_we;
   logic [31:0] ex_addr, ex_wdata;
   logic [3:0]  ex_type;
   logic        stall, dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        wb_valid;
   logic [31:0] wb_read_data;
   logic [1:0]  wb_select_word;
   logic [3:0]  wb_load_type;
   logic        timeout, addr_err;

   int errors = 0;
   int checks = 0;

   mem_access_ctrl #(.MAX_WAIT(15), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .ex_req_valid(ex_req_valid), .ex_req_we(ex_req_we), .ex_addr(ex_addr),
      .ex_wdata(ex_wdata), .ex_type(ex_type),
      .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_read_data(wb_read_data),
      .wb_select_word(wb_select_word), .wb_load_type(wb_load_type),
      .timeout(timeout), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in IDLE (cycle 0), checks the combinational stall, and
   // returns sampled in the first REQ cycle with ex_req_valid dropped.
   task automatic start(input logic we, input logic [3:0] t, input logic [31:0] a,
                        input logic [31:0] w);
      ex_req_valid = 1'b1;
      ex_req_we    = we;
      ex_type      = t;
      ex_addr      = a;
      ex_wdata     = w;
      #1;
      chk("stall_cycle0", stall, 1);
      cyc();
      ex_req_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic seen;
      rst = 1'b1;
      ex_req_valid = 1'b0; ex_req_we = 1'b0; ex_addr = '0; ex_wdata = '0;
      ex_type = Type_LW; dm_ack = 1'b0; dm_rdata = '0;
      #2;
      chk("rst_dm_req", dm_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_rdata", wb_read_data, 0);
      cyc();
      rst = 1'b0;
      cyc();

      // LW at 0x100, immediate ack
      start(1'b0, Type_LW, 32'h100, 32'h0);
      chk("lw_dm_req", dm_req, 1);
      chk("lw_stall_c1", stall, 1);
      chk("lw_dm_addr", dm_addr, 32'h100);
      chk("lw_dm_be", dm_be, 4'b1111);
      chk("lw_dm_we", dm_we, 0);
      chk("lw_dm_wdata", dm_wdata, 0);
      dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
      cyc();
      dm_ack = 1'b0;
      chk("lw_wb_valid", wb_valid, 1);
      chk("lw_stall_c2", stall, 0);
      chk("lw_rdata", wb_read_data, 32'hDEADBEEF);
      chk("lw_sel", wb_select_word, 0);
      chk("lw_type", wb_load_type, Type_LW);
      chk("lw_dm_req_done", dm_req, 0);
      cyc();
      chk("lw_wb_pulse", wb_valid, 0);
      chk("lw_rdata_hold", wb_read_data, 32'hDEADBEEF);

      // SB at 0x103
      start(1'b1, Type_SB, 32'h103, 32'h000000A5);
      chk("sb_dm_be", dm_be, 4'b1000);
      chk("sb_dm_wdata", dm_wdata, 32'hA5A5A5A5);
      chk("sb_dm_addr", dm_addr, 32'h100);
      chk("sb_dm_we", dm_we, 1);
      dm_ack = 1'b1; dm_rdata = 32'h11111111;
      cyc();
      dm_ack = 1'b0;
      chk("sb_wb_valid", wb_valid, 1);
      chk("sb_rdata_zero", wb_read_data, 0);
      chk("sb_sel", wb_select_word, 3);
      cyc();

      // SH at 0x202 and LB at 0x102
      start(1'b1, Type_SH, 32'h202, 32'h1234BEEF);
      chk("sh_dm_be", dm_be, 4'b1100);
      chk("sh_dm_wdata", dm_wdata, 32'hBEEFBEEF);
      dm_ack = 1'b1;
      cyc();
      dm_ack = 1'b0;
      cyc();
      start(1'b0, Type_LB, 32'h102, 32'hFFFFFFFF);
      chk("lb_dm_be", dm_be, 4'b0100);
      chk("lb_dm_wdata", dm_wdata, 0);
      dm_ack = 1'b1;
      cyc();
      dm_ack = 1'b0;
      cyc();

      // Unknown type treated as word
      start(1'b1, 4'hF, 32'h100, 32'hCAFEF00D);
      chk("unk_dm_be", dm_be, 4'b1111);
      chk("unk_dm_wdata", dm_wdata, 32'hCAFEF00D);
      dm_ack = 1'b1;
      cyc();
      dm_ack = 1'b0;
      cyc();

      // LH at 0x202, ack on the fifth REQ cycle: stall high cycles 0-5
      start(1'b0, Type_LH, 32'h202, 32'h0);
      chk("lh_dm_be", dm_be, 4'b1100);
      seen = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (!stall || !dm_req || wb_valid) seen = 1'b1;
         if (k == 5) begin
            dm_ack = 1'b1; dm_rdata = 32'h12345678;
         end else cyc();
      end
      chk("lh_held_5", seen, 0);
      cyc();
      dm_ack = 1'b0;
      chk("lh_stall_c6", stall, 0);
      chk("lh_wb_valid", wb_valid, 1);
      chk("lh_rdata", wb_read_data, 32'h12345678);
      chk("lh_sel", wb_select_word, 2);
      chk("lh_type", wb_load_type, Type_LH);
      cyc();

      // No ack: timeout after 15 REQ cycles
      start(1'b0, Type_LW, 32'h300, 32'h0);
      n = 1; seen = 1'b0;
      while (!timeout && n < 40) begin
         if (wb_valid) seen = 1'b1;
         cyc();
         n++;
      end
      chk("tmo_seen", timeout, 1);
      chk("tmo_cycle", n, 16);
      chk("tmo_wb_before", seen, 0);
      chk("tmo_wb_valid", wb_valid, 0);
      chk("tmo_stall", stall, 0);
      cyc();
      chk("tmo_pulse", timeout, 0);
      chk("tmo_idle_req", dm_req, 0);
      chk("tmo_idle_stall", stall, 0);
      cyc();

      // Asynchronous reset during REQ
      start(1'b0, Type_LW, 32'h400, 32'h0);
      chk("rst_mid_req_before", dm_req, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_dm_req", dm_req, 0);
      chk("rst_mid_stall", stall, 0);
      dm_ack = 1'b1;
      cyc();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (wb_valid || dm_req) seen = 1'b1;
         cyc();
      end
      dm_ack = 1'b0;
      chk("rst_mid_no_wb", seen, 0);

      // Misaligned LW at 0x101
      ex_req_valid = 1'b1; ex_req_we = 1'b0; ex_type = Type_LW; ex_addr = 32'h101;
      #1;
      chk("mis_stall_c0", stall, 1);
      cyc();
      ex_req_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
      chk("mis_dm_req", dm_req, 0);
      chk("mis_addr_err", addr_err, 1);
      chk("mis_wb_valid", wb_valid, 0);
      cyc();
      chk("mis_addr_err_pulse", addr_err, 0);
      chk("mis_dm_req_after", dm_req, 0);
`else
      chk("mis_dm_req", dm_req, 1);
      chk("mis_dm_be", dm_be, 4'b1111);
      chk("mis_dm_addr", dm_addr, 32'h100);
      chk("mis_addr_err", addr_err, 0);
      dm_ack = 1'b1;
      cyc();
      dm_ack = 1'b0;
      chk("mis_wb_valid", wb_valid, 1);
      chk("mis_sel", wb_select_word, 1);
      cyc();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
